// File: rtl/uart_cmd_decoder_if.sv
// Character-in / command-out handshake bundle for uart_cmd_decoder.
// The decoder connects to the slave modport; the character source and command consumer use master.
interface uart_cmd_decoder_if #(
    parameter int DATA_W = 7,
    parameter int CMD_W  = 4
);
    logic [DATA_W-1:0] datain;
    logic              newdata;
    logic [CMD_W-1:0]  cmd_out;
    logic              cmd_valid;
    logic              cmd_ready;

    modport master (
        output datain, newdata, cmd_ready,
        input  cmd_out, cmd_valid
    );

    modport slave (
        input  datain, newdata, cmd_ready,
        output cmd_out, cmd_valid
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses CR-terminated ASCII command lines into codes queued in a first-word fall-through FIFO.
// Define CMD_CASE_INSENSITIVE_EN to also accept 'T', 'R' and 'U'.
module uart_cmd_decoder #(
    parameter int DATA_W     = 7,
    parameter int CMD_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_cmd_decoder_if.slave             bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {IDLE, GOT_T, GOT_ARG, DISCARD} state_t;

    state_t             state, state_n;
    logic [CMD_W-1:0]   code, code_n;
    logic               push_req, err_n;

    logic [DATA_W-1:0]  data_q;
    logic               nd_q, nd_prev, smp_vld;
    logic               accept;
    logic [7:0]         raw, ch;

    logic [CMD_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               full, pop, wr;

    // nd_prev only follows nd_q once nd_q holds a real sample, so a strobe
    // held high through reset release is never seen as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            nd_q    <= 1'b0;
            nd_prev <= 1'b1;
            smp_vld <= 1'b0;
        end else begin
            data_q  <= bus.datain;
            nd_q    <= bus.newdata;
            smp_vld <= 1'b1;
            if (smp_vld)
                nd_prev <= nd_q;
        end
    end

    assign accept = nd_q & ~nd_prev;
    assign raw    = 8'(data_q);

`ifdef CMD_CASE_INSENSITIVE_EN
    always_comb begin
        ch = raw;
        if (raw == "T" || raw == "R" || raw == "U")
            ch = raw | 8'h20;
    end
`else
    assign ch = raw;
`endif

    always_comb begin
        state_n  = state;
        code_n   = code;
        push_req = 1'b0;
        err_n    = 1'b0;
        if (accept && ch != CH_LF) begin
            unique case (state)
                IDLE: begin
                    if (ch == CH_CR) begin
                        state_n = IDLE;
                    end else if (ch == "t") begin
                        state_n = GOT_T;
                    end else if (ch == "1") begin
                        state_n = GOT_ARG; code_n = CMD_W'(1);
                    end else if (ch == "2") begin
                        state_n = GOT_ARG; code_n = CMD_W'(2);
                    end else if (ch == "r") begin
                        state_n = GOT_ARG; code_n = CMD_W'(5);
                    end else if (ch == "u") begin
                        state_n = GOT_ARG; code_n = CMD_W'(6);
                    end else begin
                        state_n = DISCARD; err_n = 1'b1;
                    end
                end
                GOT_T: begin
                    if (ch == "1") begin
                        state_n = GOT_ARG; code_n = CMD_W'(3);
                    end else if (ch == "2") begin
                        state_n = GOT_ARG; code_n = CMD_W'(4);
                    end else if (ch == CH_CR) begin
                        state_n = IDLE; err_n = 1'b1;
                    end else begin
                        state_n = DISCARD; err_n = 1'b1;
                    end
                end
                GOT_ARG: begin
                    if (ch == CH_CR) begin
                        state_n = IDLE; push_req = 1'b1;
                    end else begin
                        state_n = DISCARD; err_n = 1'b1;
                    end
                end
                DISCARD: begin
                    if (ch == CH_CR)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = (fifo_count != '0);
    assign bus.cmd_out   = bus.cmd_valid ? mem[rd_ptr] : '0;
    assign full          = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop           = bus.cmd_valid & bus.cmd_ready;
    assign wr            = push_req & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            code       <= '0;
            err        <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
            err   <= err_n;
            if (push_req && full && !pop)
                overflow <= 1'b1;
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)
                fifo_count <= fifo_count + (AW+1)'(1);
            else if (pop && !wr)
                fifo_count <= fifo_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= code;
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: table of command lines plus hand-written
// sequences for latency, overflow, simultaneous push/pop and reset behaviour.
module tb_uart_cmd_decoder;
    localparam int DATA_W     = 7;
    localparam int CMD_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int NV         = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] fifo_count;
    logic          err;
    logic          overflow;

    uart_cmd_decoder_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

    uart_cmd_decoder #(.DATA_W(DATA_W), .CMD_W(CMD_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .err        (err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string s;
        int    errs;
        int    npop;
        int    code;
    } vec_t;

    vec_t             vecs [NV];
    int               checks = 0;
    int               errors = 0;
    int               err_pulses = 0;
    logic [CMD_W-1:0] pops [$];

    // Record every accepted command and every cycle err is high.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid && bus.cmd_ready)
                pops.push_back(bus.cmd_out);
            if (err)
                err_pulses++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input int hold);
        bus.datain  = c[DATA_W-1:0];
        bus.newdata = 1'b1;
        tick(hold);
        bus.newdata = 1'b0;
        tick(2);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i], 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    int e0, p0;

    initial begin
        vecs[0]  = '{"1\015",         0, 1, 1};
        vecs[1]  = '{"2\015",         0, 1, 2};
        vecs[2]  = '{"t1\015",        0, 1, 3};
        vecs[3]  = '{"t2\015",        0, 1, 4};
        vecs[4]  = '{"r\015",         0, 1, 5};
        vecs[5]  = '{"u\015",         0, 1, 6};
        vecs[6]  = '{"\015",          0, 0, 0};
        vecs[7]  = '{"t\0121\015",    0, 1, 3};
        vecs[8]  = '{"tx1\015",       1, 0, 0};
        vecs[9]  = '{"t\015",         1, 0, 0};
        vecs[10] = '{"1x\015",        1, 0, 0};
        vecs[11] = '{"z\015",         1, 0, 0};
        vecs[12] = '{"2\012\015",     0, 1, 2};
        vecs[13] = '{"tx\0151\015",   1, 1, 1};
`ifdef CMD_CASE_INSENSITIVE_EN
        vecs[14] = '{"T1\015",        0, 1, 3};
`else
        vecs[14] = '{"T1\015",        1, 0, 0};
`endif

        rst_n         = 1'b0;
        bus.datain    = '0;
        bus.newdata   = 1'b0;
        bus.cmd_ready = 1'b0;
        tick(3);
        check("rst_valid", int'(bus.cmd_valid), 0);
        check("rst_out",   int'(bus.cmd_out),   0);
        check("rst_count", int'(fifo_count),    0);
        check("rst_err",   int'(err),           0);
        check("rst_ovf",   int'(overflow),      0);
        rst_n = 1'b1;
        tick(3);

        // Table of single command lines, consumer always ready.
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            e0 = err_pulses;
            p0 = pops.size();
            send_str(vecs[i].s);
            tick(3);
            check($sformatf("v%0d_err", i),   err_pulses - e0,   vecs[i].errs);
            check($sformatf("v%0d_npop", i),  pops.size() - p0,  vecs[i].npop);
            check($sformatf("v%0d_count", i), int'(fifo_count),  0);
            if (vecs[i].npop > 0 && pops.size() > p0)
                check($sformatf("v%0d_code", i), int'(pops[p0]), vecs[i].code);
        end
        check("empty_out", int'(bus.cmd_out), 0);

        // Held command with consumer stalled, then released.
        bus.cmd_ready = 1'b0;
        e0 = err_pulses;
        p0 = pops.size();
        send_str("t1\015");
        tick(2);
        check("hold_valid", int'(bus.cmd_valid), 1);
        check("hold_out",   int'(bus.cmd_out),   3);
        check("hold_count", int'(fifo_count),    1);
        check("hold_err",   err_pulses - e0,     0);
        bus.cmd_ready = 1'b1;
        tick(1);
        check("hold_drain", int'(fifo_count), 0);
        check("hold_npop",  pops.size() - p0, 1);
        tick(2);

        // Two commands back to back with consumer ready.
        p0 = pops.size();
        send_str("t2\0151\015");
        tick(3);
        check("b2b_npop", pops.size() - p0, 2);
        if (pops.size() - p0 == 2) begin
            check("b2b_code0", int'(pops[p0]),     4);
            check("b2b_code1", int'(pops[p0 + 1]), 1);
        end

        // Latency: rising strobe at edge k, valid from edge k+1.
        bus.cmd_ready = 1'b0;
        send("u", 1);
        bus.datain  = 7'h0D;
        bus.newdata = 1'b1;
        tick(1);
        check("lat_k",  int'(bus.cmd_valid), 0);
        tick(1);
        check("lat_k1", int'(bus.cmd_valid), 1);
        check("lat_out", int'(bus.cmd_out),  6);
        bus.newdata = 1'b0;
        tick(2);
        bus.cmd_ready = 1'b1;
        tick(3);
        check("lat_drain", int'(fifo_count), 0);

        // Overflow: five commands into a four-entry queue.
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_str("r\015");
        tick(2);
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_flag",  int'(overflow),   1);
        p0 = pops.size();
        bus.cmd_ready = 1'b1;
        tick(6);
        check("ovf_npop", pops.size() - p0, 4);
        for (int j = 0; j < 4; j++)
            if (pops.size() > p0 + j)
                check($sformatf("ovf_code%0d", j), int'(pops[p0 + j]), 5);
        check("ovf_sticky", int'(overflow),   1);
        check("ovf_empty",  int'(fifo_count), 0);
        pulse_reset();
        check("ovf_clear",  int'(overflow),   0);

        // Push and pop on the same edge while full.
        bus.cmd_ready = 1'b0;
        send_str("1\0152\0151\0152\015");
        send("r", 1);
        check("pp_full", int'(fifo_count), 4);
        p0 = pops.size();
        bus.datain  = 7'h0D;
        bus.newdata = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        bus.newdata   = 1'b0;
        check("pp_count", int'(fifo_count), 4);
        check("pp_ovf",   int'(overflow),   0);
        bus.cmd_ready = 1'b1;
        tick(6);
        check("pp_npop", pops.size() - p0, 5);
        if (pops.size() - p0 == 5) begin
            check("pp_c0", int'(pops[p0]),     1);
            check("pp_c1", int'(pops[p0 + 1]), 2);
            check("pp_c2", int'(pops[p0 + 2]), 1);
            check("pp_c3", int'(pops[p0 + 3]), 2);
            check("pp_c4", int'(pops[p0 + 4]), 5);
        end

        // Long strobe gives a single character.
        p0 = pops.size();
        e0 = err_pulses;
        send("u", 10);
        send(8'h0D, 1);
        tick(2);
        check("long_npop", pops.size() - p0, 1);
        if (pops.size() > p0)
            check("long_code", int'(pops[p0]), 6);
        check("long_err", err_pulses - e0, 0);

        // Reset mid-command drops the pending 't'.
        send("t", 1);
        pulse_reset();
        p0 = pops.size();
        send_str("1\015");
        tick(2);
        check("midrst_npop", pops.size() - p0, 1);
        if (pops.size() > p0)
            check("midrst_code", int'(pops[p0]), 1);

        // Strobe held high across reset release is not a character.
        p0 = pops.size();
        e0 = err_pulses;
        bus.datain  = 7'h31;
        bus.newdata = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        bus.newdata = 1'b0;
        tick(2);
        send(8'h0D, 1);
        tick(2);
        check("rsthold_npop", pops.size() - p0, 0);
        check("rsthold_err",  err_pulses - e0,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
